// File: rtl/nes_controller_model_if.sv
// Controller-side bus of the NES pad model: console drives buttons/strobes, pad returns serial data.
interface nes_controller_model_if;
  logic [7:0] buttons_B;
  logic       clk_enable;
  logic       latch;
  logic       data_out_B;
  logic [3:0] shift_count;

  modport master (output buttons_B, clk_enable, latch, input data_out_B, shift_count);
  modport slave  (input buttons_B, clk_enable, latch, output data_out_B, shift_count);
endinterface

// File: rtl/nes_controller_model.sv
// CD4021-style NES pad: parallel load on latch, MSB-first serial shift on clk_enable.
// Optional CONTROLLER_INPUT_SYNC_EN adds a 2-flop synchroniser on buttons_B ahead of the load mux.
module nes_controller_model #(
  parameter logic FILL_BIT = 1'b0
) (
  input logic                   clk,
  input logic                   rst_B,
  nes_controller_model_if.slave ctl
);

  logic [7:0] shift_reg;
  logic [3:0] count;
  logic [7:0] load_val;

`ifdef CONTROLLER_INPUT_SYNC_EN
  logic [7:0] sync_q1, sync_q2;

  // Reset to all-released so a load right after reset sees no presses.
  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      sync_q1 <= 8'hFF;
      sync_q2 <= 8'hFF;
    end else begin
      sync_q1 <= ctl.buttons_B;
      sync_q2 <= sync_q1;
    end
  end

  assign load_val = sync_q2;
`else
  assign load_val = ctl.buttons_B;
`endif

  // Latch wins over clk_enable; count saturates at 8 so it never wraps.
  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      shift_reg <= 8'hFF;
      count     <= 4'd0;
    end else if (ctl.latch) begin
      shift_reg <= load_val;
      count     <= 4'd0;
    end else if (ctl.clk_enable) begin
      shift_reg <= {shift_reg[6:0], FILL_BIT};
      if (count != 4'd8) count <= count + 4'd1;
    end
  end

  assign ctl.data_out_B  = shift_reg[7];
  assign ctl.shift_count = count;

endmodule

// File: tb/tb_nes_controller_model.sv
// Randomized + directed bench for nes_controller_model, FILL_BIT=0 and FILL_BIT=1 side by side.
module tb_nes_controller_model;
  logic clk = 1'b0;
  logic rst_B = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nes_controller_model_if b0 ();
  nes_controller_model_if b1 ();

  nes_controller_model #(.FILL_BIT(1'b0)) dut0 (.clk(clk), .rst_B(rst_B), .ctl(b0));
  nes_controller_model #(.FILL_BIT(1'b1)) dut1 (.clk(clk), .rst_B(rst_B), .ctl(b1));

  // Reference: captured byte plus number of bits already consumed.
  logic [7:0] cap;
  int         cnt;
  logic [7:0] hist1, hist2;   // button samples one and two edges ago

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_out(input logic fill);
    if (cnt >= 8) return int'(fill);
    return int'(cap[7 - cnt]);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out0"}, int'(b0.data_out_B), model_out(1'b0));
    chk({tag, ".out1"}, int'(b1.data_out_B), model_out(1'b1));
    chk({tag, ".cnt0"}, int'(b0.shift_count), cnt);
    chk({tag, ".cnt1"}, int'(b1.shift_count), cnt);
  endtask

  task automatic model_reset();
    cap   = 8'hFF;
    cnt   = 0;
    hist1 = 8'hFF;
    hist2 = 8'hFF;
  endtask

  // Apply inputs, take one edge, update the reference, check at the falling edge.
  task automatic tick(input logic lt, input logic en, input logic [7:0] b, input string tag);
    logic [7:0] ld;
    b0.latch = lt; b0.clk_enable = en; b0.buttons_B = b;
    b1.latch = lt; b1.clk_enable = en; b1.buttons_B = b;
    @(posedge clk);
`ifdef CONTROLLER_INPUT_SYNC_EN
    ld = hist2;
`else
    ld = b;
`endif
    hist2 = hist1;
    hist1 = b;
    if (lt) begin
      cap = ld;
      cnt = 0;
    end else if (en) begin
      cnt = (cnt < 8) ? cnt + 1 : 8;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_B = 1'b0;
    #1;
    model_reset();
    chk({tag, ".async_out0"}, int'(b0.data_out_B), 1);
    chk({tag, ".async_out1"}, int'(b1.data_out_B), 1);
    chk({tag, ".async_cnt0"}, int'(b0.shift_count), 0);
    @(negedge clk);
    rst_B = 1'b1;
  endtask

  // Buttons held for 3 edges before the latch so both build variants load the same value.
  task automatic load(input logic [7:0] b, input string tag);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, b, tag);
    tick(1'b1, 1'b0, b, tag);
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] rb;
    model_reset();
    b0.latch = 0; b0.clk_enable = 0; b0.buttons_B = 8'hFF;
    b1.latch = 0; b1.clk_enable = 0; b1.buttons_B = 8'hFF;
    repeat (2) @(negedge clk);
    chk("reset.out", int'(b0.data_out_B), 1);
    chk("reset.cnt", int'(b0.shift_count), 0);
    rst_B = 1'b1;

    // Basic read
    seq = 8'b01110110;
    load(seq, "basic_load");
    chk("basic.bit7", int'(b0.data_out_B), 0);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1, seq, "basic_shift");
      chk("basic.cnt", int'(b0.shift_count), i);
      if (i < 8) chk("basic.bit", int'(b0.data_out_B), int'(seq[7 - i]));
    end
    // Fill level
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 8'h5A, "fill");
      chk("fill.out1", int'(b1.data_out_B), 1);
      chk("fill.out0", int'(b0.data_out_B), 0);
      chk("fill.cnt", int'(b1.shift_count), 8);
    end

    // Latch priority and hold
    seq = 8'b11011001;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, seq, "prio_pre");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, seq, "prio");
    chk("prio.out", int'(b0.data_out_B), 1);
    chk("prio.cnt", int'(b0.shift_count), 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 8'h00, "hold");
    chk("hold.out", int'(b0.data_out_B), 1);
    chk("hold.cnt", int'(b0.shift_count), 0);
    tick(1'b0, 1'b1, 8'h00, "prio_shift");
    chk("prio.bit6", int'(b0.data_out_B), 1);

    // Mid-operation reload
    load(8'hFF, "reload_pre");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'hFF, "reload_shift");
    load(8'h00, "reload");
    chk("reload.cnt", int'(b0.shift_count), 0);
    chk("reload.out", int'(b0.data_out_B), 0);

    // Reset during shift, then a fresh full read
    seq = 8'b00101101;
    load(seq, "rst_load");
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, seq, "rst_shift");
    reset_pulse("midreset");
    load(seq, "rst_reload");
    chk("rst_reload.bit7", int'(b0.data_out_B), 0);
    for (int i = 1; i < 8; i++) begin
      tick(1'b0, 1'b1, seq, "rst_seq");
      chk("rst_seq.bit", int'(b0.data_out_B), int'(seq[7 - i]));
    end

`ifdef CONTROLLER_INPUT_SYNC_EN
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'hAA, "sync_pre");
    tick(1'b0, 1'b0, 8'h55, "sync_chg");
    tick(1'b1, 1'b0, 8'h55, "sync_early");
    chk("sync.old", int'(b0.data_out_B), 1);
    tick(1'b0, 1'b0, 8'h55, "sync_wait");
    tick(1'b1, 1'b0, 8'h55, "sync_late");
    chk("sync.new", int'(b0.data_out_B), 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 99) == 0) reset_pulse("rand_rst");
      else tick(($urandom_range(0, 7) == 0), 1'($urandom), rb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
